// File: rtl/instr_feeder_if.sv
// Instruction-side bus between program ROM, instr_feeder and the processor.
// The master modport is the feeder; the slave modport is the ROM/processor/host side.
interface instr_feeder_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_data;
  logic [8:0]        din;
  logic              run;
  logic              done;
  logic              busy;
  logic              halted;
  logic              error;
  logic [ADDR_W-1:0] pc;

  modport master (
    input  start, mem_data, done,
    output mem_addr, din, run, busy, halted, error, pc
  );

  modport slave (
    output start, mem_data, done,
    input  mem_addr, din, run, busy, halted, error, pc
  );
endinterface

// File: rtl/instr_feeder.sv
// Fetches instructions (plus the mvi immediate) from a synchronous ROM and
// hands them to the processor one at a time, with a Run pulse and a Done watchdog.
module instr_feeder #(
  parameter int ADDR_W   = 5,
  parameter int PROG_LEN = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_feeder_if.master bus
);

  // One extra PC bit so PC can sit at PROG_LEN even when PROG_LEN == 2^ADDR_W.
  localparam int PC_W = ADDR_W + 1;
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PROG_LEN - 1);
  localparam logic [PC_W-1:0] PC_END   = PC_W'(PROG_LEN);
  localparam logic [PC_W-1:0] PC_MAX   = PC_W'((1 << ADDR_W) - 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
  localparam logic [2:0]      OP_MVI   = 3'b001;
  localparam logic [2:0]      OP_HALT  = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_F_REQ,
    S_F_CAP,
    S_I_REQ,
    S_I_CAP,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERROR
  } state_t;

  state_t            state, state_next;
  logic [PC_W-1:0]   pc_cnt, pc_next, pc_inc;
  logic [ADDR_W-1:0] mem_addr_q, addr_next;
  logic [8:0]        din_q, din_next;
  logic [8:0]        ir_buf, ir_next;
  logic [8:0]        imm_buf, imm_next;
  logic [WD_W-1:0]   wd, wd_next;
  logic [8:0]        hold_word;

  assign pc_inc    = (pc_cnt == PC_END) ? pc_cnt : pc_cnt + 1'b1;
  assign hold_word = (ir_buf[2:0] == OP_MVI) ? imm_buf : 9'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc_cnt     <= '0;
      mem_addr_q <= '0;
      din_q      <= '0;
      ir_buf     <= '0;
      imm_buf    <= '0;
      wd         <= '0;
    end else begin
      state      <= state_next;
      pc_cnt     <= pc_next;
      mem_addr_q <= addr_next;
      din_q      <= din_next;
      ir_buf     <= ir_next;
      imm_buf    <= imm_next;
      wd         <= wd_next;
    end
  end

  // DIN is computed for the state being entered, so it is valid for the whole cycle.
  always_comb begin
    state_next = state;
    pc_next    = pc_cnt;
    addr_next  = mem_addr_q;
    ir_next    = ir_buf;
    imm_next   = imm_buf;
    wd_next    = wd;
    din_next   = 9'd0;
    case (state)
      S_IDLE, S_HALT, S_ERROR: begin
        if (bus.start) begin
          state_next = S_F_REQ;
          pc_next    = '0;
          addr_next  = '0;
        end
      end
      S_F_REQ: state_next = S_F_CAP;
      S_F_CAP: begin
        ir_next = bus.mem_data;
        pc_next = pc_inc;
        if (bus.mem_data[2:0] == OP_HALT) begin
          state_next = S_HALT;
        end else if (bus.mem_data[2:0] == OP_MVI && pc_cnt == PC_LAST) begin
          state_next = S_ERROR;
        end else if (bus.mem_data[2:0] == OP_MVI) begin
          state_next = S_I_REQ;
          addr_next  = pc_inc[ADDR_W-1:0];
        end else begin
          state_next = S_ISSUE;
          din_next   = bus.mem_data;
        end
      end
      S_I_REQ: state_next = S_I_CAP;
      S_I_CAP: begin
        imm_next   = bus.mem_data;
        pc_next    = pc_inc;
        state_next = S_ISSUE;
        din_next   = ir_buf;
      end
      S_ISSUE: begin
        wd_next    = '0;
        state_next = S_WAIT;
        din_next   = hold_word;
      end
      S_WAIT: begin
        if (bus.done) begin
          if (pc_cnt == PC_END) begin
            state_next = S_HALT;
          end else begin
            state_next = S_F_REQ;
            addr_next  = pc_cnt[ADDR_W-1:0];
          end
        end else if (wd == WD_LIMIT) begin
          state_next = S_ERROR;
        end else begin
          wd_next  = wd + 1'b1;
          din_next = hold_word;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.din      = din_q;
  assign bus.run      = (state == S_ISSUE);
  assign bus.busy     = !(state == S_IDLE || state == S_HALT || state == S_ERROR);
  assign bus.halted   = (state == S_HALT);
  assign bus.error    = (state == S_ERROR);
  assign bus.pc       = (pc_cnt > PC_MAX) ? {ADDR_W{1'b1}} : pc_cnt[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: a small ROM model plus hand-computed
// expectations for fetch, mvi, watchdog, missing immediate, halt and reset.
module tb_instr_feeder;
  localparam int ADDR_W   = 5;
  localparam int PROG_LEN = 4;
  localparam int TIMEOUT  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] rom [0:31];
  logic       saw_run;
  logic       found;

  instr_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_feeder #(
    .ADDR_W  (ADDR_W),
    .PROG_LEN(PROG_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears one cycle after it is presented.
  always @(posedge clk) bus.mem_data <= rom[bus.mem_addr];

  task automatic set_rom(input logic [8:0] w0, input logic [8:0] w1,
                         input logic [8:0] w2, input logic [8:0] w3);
    for (int i = 0; i < 32; i++) rom[i] = 9'h007;
    rom[0] = w0;
    rom[1] = w1;
    rom[2] = w2;
    rom[3] = w3;
  endtask

  // Leaves the bench at the falling edge just after Start was sampled.
  task automatic start_prog();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic give_done();
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.run, bus.busy, bus.halted, bus.error} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {bus.run, bus.busy, bus.halted, bus.error});
    end
    vectors++;
    if (bus.din !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_din: got %h expected 000", bus.din);
    end
    vectors++;
    if (bus.pc !== 5'd0 || bus.mem_addr !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_pc_addr: got pc=%0d addr=%0d expected 0/0", bus.pc, bus.mem_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    give_done();
    @(negedge clk);
    vectors++;
    if ({bus.run, bus.busy, bus.halted, bus.error} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL idle_ignores_done: got %b expected 0000", {bus.run, bus.busy, bus.halted, bus.error});
    end
  endtask

  task automatic test_single();
    set_rom(9'h088, 9'h007, 9'h007, 9'h007);
    start_prog();
    vectors++;
    if (bus.mem_addr !== 5'd0 || bus.busy !== 1'b1 || bus.run !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_freq: got addr=%0d busy=%b run=%b expected 0/1/0", bus.mem_addr, bus.busy, bus.run);
    end
    @(negedge clk);
    vectors++;
    if (bus.run !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_early_run: got %b expected 0", bus.run);
    end
    @(negedge clk);
    vectors++;
    if (bus.run !== 1'b1 || bus.din !== 9'h088) begin
      miscompares++;
      $display("[TB] FAIL single_issue: got run=%b din=%h expected 1/088", bus.run, bus.din);
    end
    @(negedge clk);
    vectors++;
    if (bus.run !== 1'b0 || bus.din !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL single_wait: got run=%b din=%h expected 0/000", bus.run, bus.din);
    end
    @(negedge clk);
    give_done();
    vectors++;
    if (bus.mem_addr !== 5'd1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_refetch: got addr=%0d busy=%b expected 1/1", bus.mem_addr, bus.busy);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.pc !== 5'd2 || bus.din !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL single_halt: got halted=%b busy=%b pc=%0d din=%h expected 1/0/2/000",
               bus.halted, bus.busy, bus.pc, bus.din);
    end
    saw_run = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.run) saw_run = 1'b1;
    end
    vectors++;
    if (saw_run !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_no_rerun: got run seen=%b expected 0", saw_run);
    end
  endtask

  task automatic test_mvi();
    set_rom(9'h001, 9'h005, 9'h007, 9'h007);
    start_prog();
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.mem_addr !== 5'd1 || bus.run !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mvi_imm_req: got addr=%0d run=%b expected 1/0", bus.mem_addr, bus.run);
    end
    @(negedge clk);
    vectors++;
    if (bus.run !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mvi_early_run: got %b expected 0", bus.run);
    end
    @(negedge clk);
    vectors++;
    if (bus.run !== 1'b1 || bus.din !== 9'h001) begin
      miscompares++;
      $display("[TB] FAIL mvi_issue: got run=%b din=%h expected 1/001", bus.run, bus.din);
    end
    @(negedge clk);
    vectors++;
    if (bus.run !== 1'b0 || bus.din !== 9'h005) begin
      miscompares++;
      $display("[TB] FAIL mvi_imm_on_din: got run=%b din=%h expected 0/005", bus.run, bus.din);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.din !== 9'h005) begin
      miscompares++;
      $display("[TB] FAIL mvi_imm_held: got %h expected 005", bus.din);
    end
    give_done();
    vectors++;
    if (bus.mem_addr !== 5'd2) begin
      miscompares++;
      $display("[TB] FAIL mvi_next_addr: got %0d expected 2", bus.mem_addr);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.halted !== 1'b1 || bus.pc !== 5'd3) begin
      miscompares++;
      $display("[TB] FAIL mvi_halt: got halted=%b pc=%0d expected 1/3", bus.halted, bus.pc);
    end
  endtask

  task automatic test_timeout();
    set_rom(9'h088, 9'h007, 9'h007, 9'h007);
    start_prog();
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.run !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_issue: got run=%b expected 1", bus.run);
    end
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.pc !== 5'd1 || bus.mem_addr !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL busy_ignores_start: got busy=%b pc=%0d addr=%0d expected 1/1/0",
               bus.busy, bus.pc, bus.mem_addr);
    end
    repeat (14) @(negedge clk);
    vectors++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_early: got error=%b busy=%b expected 0/1", bus.error, bus.busy);
    end
    @(negedge clk);
    vectors++;
    if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.din !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL timeout_error: got error=%b busy=%b din=%h expected 1/0/000", bus.error, bus.busy, bus.din);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.error !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL error_sticky: got %b expected 1", bus.error);
    end
    start_prog();
    vectors++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL error_clear: got error=%b busy=%b expected 0/1", bus.error, bus.busy);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.run !== 1'b1 || bus.din !== 9'h088) begin
      miscompares++;
      $display("[TB] FAIL timeout_rerun: got run=%b din=%h expected 1/088", bus.run, bus.din);
    end
    @(negedge clk);
    give_done();
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.halted !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_final_halt: got %b expected 1", bus.halted);
    end
  endtask

  task automatic test_missing_imm();
    set_rom(9'h088, 9'h088, 9'h088, 9'h001);
    start_prog();
    for (int r = 0; r < 3; r++) begin
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        if (bus.run) found = 1'b1;
        else @(negedge clk);
      end
      vectors++;
      if (found !== 1'b1 || bus.din !== 9'h088) begin
        miscompares++;
        $display("[TB] FAIL missing_imm_run%0d: got found=%b din=%h expected 1/088", r, found, bus.din);
      end
      @(negedge clk);
      give_done();
    end
    saw_run = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.run) saw_run = 1'b1;
    end
    vectors++;
    if (saw_run !== 1'b0 || bus.error !== 1'b1 || bus.halted !== 1'b0 || bus.pc !== 5'd4) begin
      miscompares++;
      $display("[TB] FAIL missing_imm_error: got run_seen=%b error=%b halted=%b pc=%0d expected 0/1/0/4",
               saw_run, bus.error, bus.halted, bus.pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] expect_din;
    set_rom(9'h088, 9'h0D0, 9'h088, 9'h0D0);
    start_prog();
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.run !== 1'b1 || bus.din !== 9'h088) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got run=%b din=%h expected 1/088", bus.run, bus.din);
    end
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.run !== 1'b0 || bus.mem_addr !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL issue_ignores_done: got busy=%b run=%b addr=%0d expected 1/0/0",
               bus.busy, bus.run, bus.mem_addr);
    end
    saw_run = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.run) saw_run = 1'b1;
    end
    vectors++;
    if (saw_run !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_no_early_run: got run seen=%b expected 0", saw_run);
    end
    give_done();
    @(negedge clk);
    vectors++;
    if (bus.run !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_latency_early: got run=%b expected 0", bus.run);
    end
    @(negedge clk);
    vectors++;
    if (bus.run !== 1'b1 || bus.din !== 9'h0D0) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got run=%b din=%h expected 1/0D0", bus.run, bus.din);
    end
    for (int r = 2; r < 4; r++) begin
      expect_din = (r == 2) ? 9'h088 : 9'h0D0;
      @(negedge clk);
      give_done();
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        if (bus.run) found = 1'b1;
        else @(negedge clk);
      end
      vectors++;
      if (found !== 1'b1 || bus.din !== expect_din) begin
        miscompares++;
        $display("[TB] FAIL b2b_run%0d: got found=%b din=%h expected 1/%h", r, found, bus.din, expect_din);
      end
    end
    @(negedge clk);
    give_done();
    vectors++;
    if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.pc !== 5'd4) begin
      miscompares++;
      $display("[TB] FAIL b2b_end_halt: got halted=%b busy=%b pc=%0d expected 1/0/4", bus.halted, bus.busy, bus.pc);
    end
  endtask

  task automatic test_reset_mid_wait();
    set_rom(9'h001, 9'h005, 9'h007, 9'h007);
    start_prog();
    repeat (4) @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.din !== 9'h005 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_setup_wait: got din=%h busy=%b expected 005/1", bus.din, bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.run !== 1'b0 || bus.din !== 9'h000 || bus.pc !== 5'd0 || bus.busy !== 1'b0 || bus.mem_addr !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_async_abort: got run=%b din=%h pc=%0d busy=%b addr=%0d expected 0/000/0/0/0",
               bus.run, bus.din, bus.pc, bus.busy, bus.mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      give_done();
      if (bus.run || bus.busy) saw_run = 1'b1;
    end
    vectors++;
    if (saw_run !== 1'b0 || bus.pc !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_done_ignored: got activity=%b pc=%0d expected 0/0", saw_run, bus.pc);
    end
    start_prog();
    repeat (4) @(negedge clk);
    vectors++;
    if (bus.run !== 1'b1 || bus.din !== 9'h001) begin
      miscompares++;
      $display("[TB] FAIL rst_restart: got run=%b din=%h expected 1/001", bus.run, bus.din);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.done  = 1'b0;
    set_rom(9'h007, 9'h007, 9'h007, 9'h007);
    test_reset();
    test_single();
    test_mvi();
    test_timeout();
    test_missing_imm();
    test_back_to_back();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
